// File: rtl/ew_out_writer_if.sv
// Bundle for the output-pixel stream plus the AXI write channels (AW, W, B).
// The writer uses the master side of this bundle.
interface ew_out_writer_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                    s_dat_valid;
  logic                    s_dat_ready;
  logic [DATA_WIDTH-1:0]   s_dat;

  logic [ID_WIDTH-1:0]     M_AXI_AWID;
  logic [31:0]             M_AXI_AWADDR;
  logic [7:0]              M_AXI_AWLEN;
  logic [2:0]              M_AXI_AWSIZE;
  logic [1:0]              M_AXI_AWBURST;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;

  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WLAST;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;

  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [1:0]              M_AXI_BRESP;

  modport master (
    input  s_dat_valid, s_dat, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output s_dat_ready, M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY
  );

  modport slave (
    output s_dat_valid, s_dat, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  s_dat_ready, M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY
  );
endinterface

// File: rtl/ew_out_writer.sv
// Writes a C x H x W output tensor to memory as AXI INCR bursts, one burst sequence per row,
// streaming pixel-group beats straight from s_dat to WDATA.
module ew_out_writer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] Hout,
  input  logic [15:0] Wout,
  input  logic [15:0] CH_div_Tout,
  input  logic [31:0] out_base_addr,
  input  logic [31:0] surface_stride,
  input  logic [31:0] line_stride,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_cnt,
  ew_out_writer_if.master axi
);
  localparam int unsigned Bytes   = DATA_WIDTH / 8;
  localparam int unsigned SizeLog = $clog2(Bytes);

  typedef enum logic [2:0] {StIdle, StAw, StW, StWaitB, StDone} state_e;
  state_e st_q, st_d;

  logic [15:0] h_max_q, h_max_d, w_max_q, w_max_d, c_max_q, c_max_d;
  logic [31:0] surf_stride_q, surf_stride_d, line_stride_q, line_stride_d;
  logic [15:0] h_q, h_d, w_q, w_d, c_q, c_d;
  logic [31:0] surf_addr_q, surf_addr_d, row_addr_q, row_addr_d;
  logic [8:0]  beats_q, beats_d, beat_q, beat_d;
  logic [31:0] bursts_q, bursts_d, b_cnt_q, b_cnt_d, perf_q, perf_d;

  logic [15:0] rem;
  logic [8:0]  len;
  logic [15:0] w_next;
  logic        w_fire;
  logic        unused_bresp;

  assign unused_bresp = ^axi.M_AXI_BRESP;

  // Beats left in the current row, capped at the burst limit.
  assign rem    = w_max_q - w_q;
  assign len    = (rem >= 16'(MAX_BURST)) ? 9'(MAX_BURST) : rem[8:0];
  assign w_next = w_q + {7'd0, beats_q};
  assign w_fire = (st_q == StW) && axi.s_dat_valid && axi.M_AXI_WREADY;

  always_comb begin
    st_d          = st_q;
    h_max_d       = h_max_q;
    w_max_d       = w_max_q;
    c_max_d       = c_max_q;
    surf_stride_d = surf_stride_q;
    line_stride_d = line_stride_q;
    h_d           = h_q;
    w_d           = w_q;
    c_d           = c_q;
    surf_addr_d   = surf_addr_q;
    row_addr_d    = row_addr_q;
    beats_d       = beats_q;
    beat_d        = beat_q;
    bursts_d      = bursts_q;
    b_cnt_d       = axi.M_AXI_BVALID ? b_cnt_q + 32'd1 : b_cnt_q;
    perf_d        = (st_q != StIdle) ? perf_q + 32'd1 : perf_q;

    unique case (st_q)
      StIdle: begin
        if (start) begin
          h_max_d       = Hout;
          w_max_d       = Wout;
          c_max_d       = CH_div_Tout;
          surf_stride_d = surface_stride;
          line_stride_d = line_stride;
          h_d           = '0;
          w_d           = '0;
          c_d           = '0;
          surf_addr_d   = out_base_addr;
          row_addr_d    = out_base_addr;
          beats_d       = '0;
          beat_d        = '0;
          bursts_d      = '0;
          b_cnt_d       = '0;
          perf_d        = 32'd1;
          st_d = (Hout == '0 || Wout == '0 || CH_div_Tout == '0) ? StDone : StAw;
        end
      end
      StAw: begin
        if (axi.M_AXI_AWREADY) begin
          beats_d  = len;
          beat_d   = '0;
          bursts_d = bursts_q + 32'd1;
          st_d     = StW;
        end
      end
      StW: begin
        if (w_fire) begin
          if (beat_q == beats_q - 9'd1) begin
            beat_d = '0;
            st_d   = StAw;
            if (w_next == w_max_q) begin
              w_d = '0;
              if (h_q == h_max_q - 16'd1) begin
                h_d = '0;
                if (c_q == c_max_q - 16'd1) begin
                  st_d = StWaitB;
                end else begin
                  c_d         = c_q + 16'd1;
                  surf_addr_d = surf_addr_q + surf_stride_q;
                  row_addr_d  = surf_addr_q + surf_stride_q;
                end
              end else begin
                h_d        = h_q + 16'd1;
                row_addr_d = row_addr_q + line_stride_q;
              end
            end else begin
              w_d = w_next;
            end
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      StWaitB: if (b_cnt_q == bursts_q) st_d = StDone;
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= StIdle;
      h_max_q       <= '0;
      w_max_q       <= '0;
      c_max_q       <= '0;
      surf_stride_q <= '0;
      line_stride_q <= '0;
      h_q           <= '0;
      w_q           <= '0;
      c_q           <= '0;
      surf_addr_q   <= '0;
      row_addr_q    <= '0;
      beats_q       <= '0;
      beat_q        <= '0;
      bursts_q      <= '0;
      b_cnt_q       <= '0;
      perf_q        <= '0;
    end else begin
      st_q          <= st_d;
      h_max_q       <= h_max_d;
      w_max_q       <= w_max_d;
      c_max_q       <= c_max_d;
      surf_stride_q <= surf_stride_d;
      line_stride_q <= line_stride_d;
      h_q           <= h_d;
      w_q           <= w_d;
      c_q           <= c_d;
      surf_addr_q   <= surf_addr_d;
      row_addr_q    <= row_addr_d;
      beats_q       <= beats_d;
      beat_q        <= beat_d;
      bursts_q      <= bursts_d;
      b_cnt_q       <= b_cnt_d;
      perf_q        <= perf_d;
    end
  end

  assign busy     = (st_q != StIdle);
  assign done     = (st_q == StDone);
  assign perf_cnt = perf_q;

  assign axi.M_AXI_AWID    = '0;
  assign axi.M_AXI_AWADDR  = row_addr_q + ({16'd0, w_q} << SizeLog);
  assign axi.M_AXI_AWLEN   = 8'(len - 9'd1);
  assign axi.M_AXI_AWSIZE  = 3'(SizeLog);
  assign axi.M_AXI_AWBURST = 2'b01;
  assign axi.M_AXI_AWVALID = (st_q == StAw);
  assign axi.M_AXI_WDATA   = axi.s_dat;
  assign axi.M_AXI_WSTRB   = '1;
  assign axi.M_AXI_WVALID  = (st_q == StW) && axi.s_dat_valid;
  assign axi.M_AXI_WLAST   = (st_q == StW) && (beat_q == beats_q - 9'd1);
  assign axi.s_dat_ready   = (st_q == StW) && axi.M_AXI_WREADY;
  assign axi.M_AXI_BREADY  = 1'b1;
endmodule

// File: tb/tb_ew_out_writer.sv
// Randomised bench for ew_out_writer: a job-level address/data model feeds expectation queues
// that a negedge monitor drains as AXI handshakes appear.
module tb_ew_out_writer;
  localparam int unsigned DW  = 256;
  localparam int unsigned IDW = 4;
  localparam int unsigned MB  = 16;
  localparam int unsigned BY  = DW / 8;

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} w_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hout = '0, wout = '0, chd = '0;
  logic [31:0] base = '0, sstr = '0, lstr = '0;
  logic        busy, done;
  logic [31:0] perf_cnt;

  ew_out_writer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

  ew_out_writer #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Hout(hout), .Wout(wout), .CH_div_Tout(chd),
    .out_base_addr(base), .surface_stride(sstr), .line_stride(lstr),
    .busy(busy), .done(done), .perf_cnt(perf_cnt), .axi(bus)
  );

  always #5 clk = ~clk;

  aw_t           exp_aw[$];
  w_t            exp_w[$];
  logic [DW-1:0] src_q[$];
  int  total = 0, bad = 0;
  bit  stall = 0, mon_en = 0;
  bit  aw_fire = 0, w_fire = 0, w_last_fire = 0, s_fire = 0;
  int  done_cnt = 0, awv_cnt = 0, aw_cnt = 0, w_cnt = 0, b_pend = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Job model: channel-major walk, each row chopped into bursts of at most MB beats.
  function automatic int build_model(input int h, input int w, input int c,
                                     input logic [31:0] b, input logic [31:0] ss,
                                     input logic [31:0] ls);
    int nb = 0;
    for (int ci = 0; ci < c; ci++)
      for (int hi = 0; hi < h; hi++)
        for (int w0 = 0; w0 < w; w0 += MB) begin
          int n;
          logic [31:0] a;
          logic [DW-1:0] d;
          n = (w - w0 > MB) ? MB : w - w0;
          a = b + 32'(ci) * ss + 32'(hi) * ls + 32'(w0) * BY;
          exp_aw.push_back('{addr: a, len: 8'(n - 1)});
          nb++;
          for (int i = 0; i < n; i++) begin
            d = rnd_data();
            exp_w.push_back('{data: d, last: (i == n - 1)});
            src_q.push_back(d);
          end
        end
    return nb;
  endfunction

  // Monitor: handshakes are sampled at negedge, i.e. as they will complete on the next posedge.
  initial begin
    aw_t e;
    w_t  f;
    bit  aw_st = 0, w_st = 0;
    logic [31:0]   aw_a = '0;
    logic [7:0]    aw_l = '0;
    logic [DW-1:0] w_d = '0;
    forever begin
      @(negedge clk);
      aw_fire     = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_fire      = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      w_last_fire = w_fire && bus.M_AXI_WLAST;
      s_fire      = bus.s_dat_valid && bus.s_dat_ready;
      if (mon_en) begin
        if (bus.M_AXI_AWVALID) awv_cnt++;
        if (done) done_cnt++;
        if (aw_st) begin
          check("aw_hold_valid", 256'(bus.M_AXI_AWVALID), 256'(1));
          check("aw_hold_addr", 256'(bus.M_AXI_AWADDR), 256'(aw_a));
          check("aw_hold_len", 256'(bus.M_AXI_AWLEN), 256'(aw_l));
        end
        if (w_st) check("w_hold_data", 256'(bus.M_AXI_WDATA), 256'(w_d));
        if (aw_fire) begin
          aw_cnt++;
          if (exp_aw.size() == 0) check("aw_extra", 256'(1), 256'(0));
          else begin
            e = exp_aw.pop_front();
            check("aw_addr", 256'(bus.M_AXI_AWADDR), 256'(e.addr));
            check("aw_len", 256'(bus.M_AXI_AWLEN), 256'(e.len));
            check("aw_size", 256'(bus.M_AXI_AWSIZE), 256'(5));
            check("aw_burst", 256'(bus.M_AXI_AWBURST), 256'(1));
            check("aw_id", 256'(bus.M_AXI_AWID), 256'(0));
          end
        end
        if (w_fire) begin
          w_cnt++;
          if (exp_w.size() == 0) check("w_extra", 256'(1), 256'(0));
          else begin
            f = exp_w.pop_front();
            check("w_data", 256'(bus.M_AXI_WDATA), 256'(f.data));
            check("w_last", 256'(bus.M_AXI_WLAST), 256'(f.last));
            check("w_strb", 256'(bus.M_AXI_WSTRB), 256'({BY{1'b1}}));
          end
        end
        aw_st = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
        aw_a  = bus.M_AXI_AWADDR;
        aw_l  = bus.M_AXI_AWLEN;
        w_st  = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
        w_d   = bus.M_AXI_WDATA;
      end else begin
        aw_st = 0;
        w_st  = 0;
      end
    end
  end

  // Source and slave driver: changes only just after posedge.
  initial begin
    bus.s_dat_valid   = 1'b0;
    bus.s_dat         = '0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.s_dat_valid  = 1'b0;
        bus.M_AXI_BVALID = 1'b0;
        b_pend = 0;
      end else begin
        if (s_fire && src_q.size() > 0) void'(src_q.pop_front());
        if (s_fire || !bus.s_dat_valid) begin
          if (src_q.size() > 0 && (!stall || $urandom_range(3) != 0)) begin
            bus.s_dat_valid = 1'b1;
            bus.s_dat       = src_q[0];
          end else begin
            bus.s_dat_valid = 1'b0;
            bus.s_dat       = rnd_data();
          end
        end
        if (w_last_fire) b_pend++;
        if (b_pend > 0 && (!stall || $urandom_range(1) == 0)) begin
          bus.M_AXI_BVALID = 1'b1;
          bus.M_AXI_BRESP  = 2'($urandom_range(3));
          b_pend--;
        end else begin
          bus.M_AXI_BVALID = 1'b0;
        end
        bus.M_AXI_AWREADY = stall ? ($urandom_range(2) == 0) : 1'b1;
        bus.M_AXI_WREADY  = stall ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  task automatic run_job(input int h, input int w, input int c, input logic [31:0] b,
                         input logic [31:0] ss, input logic [31:0] ls, input bit stl,
                         input bit poke);
    int nb, cyc;
    bit got;
    stall = stl;
    nb = build_model(h, w, c, b, ss, ls);
    done_cnt = 0;
    awv_cnt  = 0;
    aw_cnt   = 0;
    @(posedge clk);
    #1;
    hout = 16'(h); wout = 16'(w); chd = 16'(c); base = b; sstr = ss; lstr = ls;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs must be ignored once the job is latched.
    hout = 16'($urandom); wout = 16'($urandom); chd = 16'($urandom);
    base = $urandom; sstr = $urandom; lstr = $urandom;
    cyc = 1;
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1;
        break;
      end
      if (poke && i == 5) start = 1'b1;
      if (poke && i == 6) start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", 256'(got), 256'(1));
    @(posedge clk);
    #1;
    check("perf_cnt", 256'(perf_cnt), 256'(cyc));
    check("busy_after", 256'(busy), 256'(0));
    repeat (4) @(negedge clk);
    check("done_pulses", 256'(done_cnt), 256'(1));
    check("aw_left", 256'(exp_aw.size()), 256'(0));
    check("w_left", 256'(exp_w.size()), 256'(0));
    check("burst_count", 256'(aw_cnt), 256'(nb));
    if (nb == 0) check("no_awvalid", 256'(awv_cnt), 256'(0));
    exp_aw.delete();
    exp_w.delete();
    src_q.delete();
  endtask

  initial begin
    bit got;
    #3;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_perf", 256'(perf_cnt), 256'(0));
    check("rst_awvalid", 256'(bus.M_AXI_AWVALID), 256'(0));
    check("rst_wvalid", 256'(bus.M_AXI_WVALID), 256'(0));
    check("rst_sready", 256'(bus.s_dat_ready), 256'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1;

    run_job(1, 4, 1, 32'h0800_0000, 32'h1000, 32'h200, 0, 0);
    run_job(2, 40, 2, 32'h0800_0000, 32'd2560, 32'd1280, 0, 0);
    run_job(2, 40, 2, 32'h0800_0000, 32'd2560, 32'd1280, 1, 0);
    run_job(3, 0, 2, 32'h0800_0000, 32'd2560, 32'd1280, 0, 0);
    run_job(0, 5, 1, 32'h0800_0000, 32'd2560, 32'd1280, 0, 0);
    run_job(1, 20, 2, 32'h0900_0000, 32'h2000, 32'h400, 1, 1);

    // Reset in the middle of the third W beat.
    stall = 0;
    void'(build_model(2, 40, 2, 32'h0800_0000, 32'd2560, 32'd1280));
    w_cnt = 0;
    @(posedge clk);
    #1;
    hout = 16'd2; wout = 16'd40; chd = 16'd2; base = 32'h0800_0000; sstr = 32'd2560;
    lstr = 32'd1280;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_cnt == 2) begin
        got = 1;
        break;
      end
    end
    check("reach_beat3", 256'(got), 256'(1));
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_awvalid", 256'(bus.M_AXI_AWVALID), 256'(0));
    check("mid_rst_wvalid", 256'(bus.M_AXI_WVALID), 256'(0));
    check("mid_rst_wlast", 256'(bus.M_AXI_WLAST), 256'(0));
    check("mid_rst_sready", 256'(bus.s_dat_ready), 256'(0));
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_done", 256'(done), 256'(0));
    check("mid_rst_perf", 256'(perf_cnt), 256'(0));
    exp_aw.delete();
    exp_w.delete();
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1;
    run_job(2, 40, 2, 32'h0800_0000, 32'd2560, 32'd1280, 1, 0);

    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(3, 1)), int'($urandom_range(40, 1)),
              int'($urandom_range(2, 1)), {$urandom_range(32'hFFFF), 16'h0000},
              32'h4000, 32'h1000, bit'($urandom_range(1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ew_out_writer.md
EW_OUT_WRITER -- requirements
Module: ew_out_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: AXI data width and s_dat width, in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per write burst (power of 2, 1..256).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a job when idle.
REQ-007 Hout, Wout, CH_div_Tout  in  16 each  output height, width, channel groups.
REQ-008 out_base_addr, surface_stride, line_stride  in  32 each  byte addresses/strides.
REQ-009 s_dat_valid/s_dat_ready  in/out  1 each; s_dat  in  DATA_WIDTH: one output pixel-group per beat.
REQ-010 M_AXI_AWID  out  ID_WIDTH (const 0); AWADDR  out  32; AWLEN  out  8; AWSIZE  out  3 (log2(DATA_WIDTH/8)); AWBURST  out  2 (INCR); AWVALID  out  1; AWREADY  in  1.
REQ-011 M_AXI_WDATA  out  DATA_WIDTH; WSTRB  out  DATA_WIDTH/8 (all ones); WLAST, WVALID  out  1; WREADY  in  1.
REQ-012 M_AXI_BVALID  in  1; BREADY  out  1 (const 1); BRESP  in  2 (ignored).
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); perf_cnt  out  32 (cycles of last job).

Function
REQ-014 On start while idle: SHALL register all job inputs; later input changes are ignored until the next job.
REQ-015 start while busy SHALL be ignored.
REQ-016 Traversal order: channel group c outer, row h, column w inner; beat address = out_base_addr + c*surface_stride + h*line_stride + w*(DATA_WIDTH/8).
REQ-017 Each row SHALL be split into bursts of min(MAX_BURST, remaining beats); AWLEN = beats-1; AWADDR = address of first beat.
REQ-018 FSM states: IDLE, AW, W, WAIT_B, DONE.
REQ-019 IDLE -> AW on accepted start; IDLE -> DONE if any of Hout, Wout, CH_div_Tout is 0, with no AXI traffic.
REQ-020 AW: AWVALID held high with AWADDR/AWLEN stable until AWREADY; then -> W.
REQ-021 W: WVALID = s_dat_valid; s_dat_ready = WREADY; WDATA = s_dat, combinational pass-through, zero added latency; a beat transfers when both valid and ready are high.
REQ-022 WLAST SHALL be high on the final beat of each burst only.
REQ-023 After the last beat of a burst: -> AW if beats remain in the job, else -> WAIT_B.
REQ-024 s_dat_ready SHALL be 0 outside the W state.
REQ-025 A 32-bit B counter SHALL increment on each BVALID, including a BVALID coinciding with the final W beat or with a state change.
REQ-026 WAIT_B -> DONE when the B count equals the number of bursts issued.
REQ-027 DONE: assert done for one cycle, -> IDLE.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 perf_cnt SHALL count cycles from start acceptance to done inclusive; it holds its value until the next start clears it.
REQ-030 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-031 The caller guarantees that no burst crosses a 4KB boundary; the block performs no check.

Reset
REQ-032 rst_n low, asynchronously at any time including mid-burst: state=IDLE; AWVALID, WVALID, WLAST, s_dat_ready, done, busy = 0; perf_cnt, B counter, beat counters = 0.
REQ-033 After reset release, the first accepted start SHALL begin a clean job with no residual burst.

Verification
REQ-034 Hout=1, Wout=4, CH_div_Tout=1, base=0x800_0000, always-ready slave -> one AW (addr 0x800_0000, AWLEN=3); 4 W beats with WLAST on beat 4; done after 1 B.
REQ-035 Hout=2, Wout=40, CH_div_Tout=2, DATA_WIDTH=256, line_stride=1280, surface_stride=2560 -> 12 bursts with AWLEN 15,15,7 per row; row-1 burst addresses 0x800_0500/0x800_0700/0x800_0900; done after 12 B.
REQ-036 Random AWREADY/WREADY/s_dat_valid stalls on the REQ-035 job -> identical AXI address/data sequence; WDATA and AWADDR stable while stalled.
REQ-037 Wout=0 -> done 2 cycles after start; no AWVALID ever asserted.
REQ-038 Assert rst_n low during the 3rd W beat -> all outputs 0 next edge; a new start then runs a complete, correct job.
REQ-039 Pulse start while busy -> ignored; job completes per its original parameters; exactly one done pulse.
